pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the saturating event counters.
REQ-002 The block SHALL use one clock, clk_i, and a synchronous, active-high reset, rst_i.
REQ-003 Port: clk_i  in  1  rising-edge clock.
REQ-004 Port: rst_i  in  1  synchronous active-high reset.
REQ-005 Port: start_i  in  1  CPU run enable.
REQ-006 Port: mem_stall_i  in  1  data-cache miss stall request.
REQ-007 Port: branch_taken_i  in  1  branch resolved taken in ID.
REQ-008 Port: ID_rs1_i, ID_rs2_i  in  5 each  ID-stage source registers.
REQ-009 Port: EX_rd_i  in  5  EX-stage destination register.
REQ-010 Port: EX_MemRead_i  in  1  EX-stage instruction is a load.
REQ-011 Port: PC_write_o  out  1  PC update enable.
REQ-012 Port: IF_ID_write_o  out  1  IF_ID register write enable.
REQ-013 Port: IF_ID_flush_o  out  1  zero the instruction captured by IF_ID.
REQ-014 Port: ID_EX_bubble_o  out  1  insert NOP into ID_EX.
REQ-015 Port: stall_o  out  1  global pipeline-register hold.
REQ-016 Port: state_o  out  2  FSM state: IDLE=0, RUN=1, MEM_WAIT=2.
REQ-017 Port: stall_cnt_o, hazard_cnt_o, flush_cnt_o  out  CNT_W each  event counters.

Function
REQ-018 State register: IDLE to RUN at the edge where start_i=1; any state to IDLE at the edge where start_i=0.
REQ-019 RUN to MEM_WAIT at the edge where mem_stall_i=1; MEM_WAIT to RUN at the edge where mem_stall_i=0.
REQ-020 In IDLE, all control outputs SHALL be 0, so the PC and IF_ID hold and IF_ID keeps inst 0.
REQ-021 Outputs in RUN and MEM_WAIT SHALL be combinational from the current inputs, with zero-cycle latency and this priority: mem stall, then load-use, then branch, then normal.
REQ-022 Mem stall (mem_stall_i=1) SHALL drive stall_o=1 and PC_write_o, IF_ID_write_o, IF_ID_flush_o and ID_EX_bubble_o all 0.
REQ-023 Load-use is EX_MemRead_i=1, EX_rd_i!=0, and EX_rd_i equal to ID_rs1_i or ID_rs2_i.
REQ-024 On load-use, PC_write_o=0, IF_ID_write_o=0, ID_EX_bubble_o=1 and IF_ID_flush_o=0, even if branch_taken_i=1; the branch re-evaluates next cycle.
REQ-025 On branch (branch_taken_i=1 with no higher-priority event), PC_write_o=1, IF_ID_write_o=1 and IF_ID_flush_o=1.
REQ-026 On normal operation, PC_write_o=1, IF_ID_write_o=1, and every other control output 0.
REQ-027 In MEM_WAIT with mem_stall_i=0, the outputs SHALL follow the RUN rules in that same cycle, with no extra dead cycle.
REQ-028 stall_cnt_o SHALL increment by 1 at each edge where stall_o=1.
REQ-029 hazard_cnt_o SHALL increment at each edge where ID_EX_bubble_o=1.
REQ-030 flush_cnt_o SHALL increment at each edge where IF_ID_flush_o=1.
REQ-031 Each counter SHALL saturate at all-ones and never wrap; counters SHALL hold in IDLE.
REQ-032 EX_rd_i=0 SHALL never produce a hazard, even when the ID source registers are 0.

Reset
REQ-033 When rst_i=1 at an edge, state SHALL become IDLE and all counters 0, overriding start_i and every other input.
REQ-034 While rst_i=1, all control outputs SHALL be 0 and state_o SHALL be 0.
REQ-035 Reset asserted mid-stall or mid-hazard SHALL abort the event with no residual stall or flush after the reset is released.

Verification
REQ-036 Startup: rst 2 cycles, then start_i=1 -> state_o goes 0 then 1 one edge later; PC_write_o=0 before that edge and 1 after.
REQ-037 Load-use: EX_MemRead_i=1, EX_rd_i=5, ID_rs2_i=5 for 1 cycle -> bubble=1 and both writes 0 for exactly 1 cycle; hazard_cnt_o=1.
REQ-038 Load-use with EX_rd_i=0 and rs1=0 -> no bubble; hazard_cnt_o unchanged.
REQ-039 Mem stall for 4 cycles with branch_taken_i=1 and a load-use present -> stall_o=1 for 4 cycles, flush 0, bubble 0; state_o=2 for 3 cycles; stall_cnt_o=4.
REQ-040 Saturation with CNT_W=2: 5 branch cycles -> flush_cnt_o=3 and held there.
REQ-041 rst_i=1 during MEM_WAIT with mem_stall_i=1 -> next cycle state_o=0, all counters 0, all outputs 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller: run FSM, zero-latency stall/bubble/flush controls,
// and saturating event counters for stalls, load-use bubbles and branch flushes.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mem_stall_i,
  input  logic             branch_taken_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic [4:0]       EX_rd_i,
  input  logic             EX_MemRead_i,
  output logic             PC_write_o,
  output logic             IF_ID_write_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_bubble_o,
  output logic             stall_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] hazard_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t state;
  logic   active;
  logic   load_use;

  // Reset gates the controls combinationally so nothing leaks out during the reset cycle.
  assign active   = !rst_i && (state != IDLE);
  assign load_use = EX_MemRead_i && (EX_rd_i != 5'd0) &&
                    ((EX_rd_i == ID_rs1_i) || (EX_rd_i == ID_rs2_i));

  always_comb begin
    PC_write_o     = 1'b0;
    IF_ID_write_o  = 1'b0;
    IF_ID_flush_o  = 1'b0;
    ID_EX_bubble_o = 1'b0;
    stall_o        = 1'b0;
    if (active) begin
      if (mem_stall_i) begin
        stall_o = 1'b1;
      end else if (load_use) begin
        // A taken branch behind a load-use is dropped; ID re-resolves it next cycle.
        ID_EX_bubble_o = 1'b1;
      end else begin
        PC_write_o    = 1'b1;
        IF_ID_write_o = 1'b1;
        IF_ID_flush_o = branch_taken_i;
      end
    end
  end

  assign state_o = rst_i ? 2'd0 : state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else if (!start_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:     state <= RUN;
        RUN:      state <= mem_stall_i ? MEM_WAIT : RUN;
        MEM_WAIT: state <= mem_stall_i ? MEM_WAIT : RUN;
        default:  state <= IDLE;
      endcase
    end
  end

  // Controls are already zero in IDLE, so the counters hold there without extra gating.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o  <= '0;
      hazard_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      if (stall_o && !(&stall_cnt_o))
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (ID_EX_bubble_o && !(&hazard_cnt_o))
        hazard_cnt_o <= hazard_cnt_o + 1'b1;
      if (IF_ID_flush_o && !(&flush_cnt_o))
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-cycle compare against a rule-level model
// plus literal expectations for startup, load-use, mem stall, reset abort and saturation.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, mem_stall, branch, memread;
  logic [4:0] rs1, rs2, rd;

  logic        pc_w, ifid_w, flush, bubble, stall;
  logic [1:0]  state;
  logic [15:0] stall_cnt, hazard_cnt, flush_cnt;

  logic        s_pc_w, s_ifid_w, s_flush, s_bubble, s_stall;
  logic [1:0]  s_state;
  logic [1:0]  s_stall_cnt, s_hazard_cnt, s_flush_cnt;

  pipe_hazard_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mem_stall_i(mem_stall),
    .branch_taken_i(branch), .ID_rs1_i(rs1), .ID_rs2_i(rs2), .EX_rd_i(rd),
    .EX_MemRead_i(memread), .PC_write_o(pc_w), .IF_ID_write_o(ifid_w),
    .IF_ID_flush_o(flush), .ID_EX_bubble_o(bubble), .stall_o(stall),
    .state_o(state), .stall_cnt_o(stall_cnt), .hazard_cnt_o(hazard_cnt),
    .flush_cnt_o(flush_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mem_stall_i(mem_stall),
    .branch_taken_i(branch), .ID_rs1_i(rs1), .ID_rs2_i(rs2), .EX_rd_i(rd),
    .EX_MemRead_i(memread), .PC_write_o(s_pc_w), .IF_ID_write_o(s_ifid_w),
    .IF_ID_flush_o(s_flush), .ID_EX_bubble_o(s_bubble), .stall_o(s_stall),
    .state_o(s_state), .stall_cnt_o(s_stall_cnt), .hazard_cnt_o(s_hazard_cnt),
    .flush_cnt_o(s_flush_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0=idle, 1=run, 2=waiting on memory; counters as plain saturating integers.
  int m_state = 0;
  int m_stall = 0, m_haz = 0, m_flush = 0;
  bit started = 0;
  localparam int CAP = 65535;

  // Expected controls as {pc, ifid, flush, bubble, stall}.
  function automatic logic [4:0] model_ctrl();
    bit lu;
    lu = memread && rd != 0 && (rd == rs1 || rd == rs2);
    if (rst || m_state == 0) return 5'b00000;
    if (mem_stall)           return 5'b00001;
    if (lu)                  return 5'b00010;
    if (branch)              return 5'b11100;
    return 5'b11000;
  endfunction

  always @(posedge clk) begin
    logic [4:0] e;
    e = model_ctrl();
    started = 1;
    if (rst) begin
      m_state = 0; m_stall = 0; m_haz = 0; m_flush = 0;
    end else begin
      if (e[0] && m_stall < CAP) m_stall++;
      if (e[1] && m_haz   < CAP) m_haz++;
      if (e[2] && m_flush < CAP) m_flush++;
      if (!start)            m_state = 0;
      else if (m_state == 0) m_state = 1;
      else                   m_state = mem_stall ? 2 : 1;
    end
  end

  always @(negedge clk) begin
    logic [4:0] e;
    if (started) begin
      e = model_ctrl();
      check("m_pc_write",  int'(pc_w),   int'(e[4]));
      check("m_ifid_write", int'(ifid_w), int'(e[3]));
      check("m_flush",     int'(flush),  int'(e[2]));
      check("m_bubble",    int'(bubble), int'(e[1]));
      check("m_stall",     int'(stall),  int'(e[0]));
      check("m_state",     int'(state),  rst ? 0 : m_state);
      check("m_stall_cnt", int'(stall_cnt),  m_stall);
      check("m_hazard_cnt", int'(hazard_cnt), m_haz);
      check("m_flush_cnt", int'(flush_cnt),  m_flush);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    mem_stall = 0; branch = 0; memread = 0; rs1 = 0; rs2 = 0; rd = 0;
  endtask

  initial begin
    int st2;
    rst = 1; start = 0;
    clear_ops();
    step();
    @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_pc", int'(pc_w), 0);
    check("rst_cnt", int'(stall_cnt) + int'(hazard_cnt) + int'(flush_cnt), 0);
    step();

    // Startup.
    rst = 0; start = 1;
    @(negedge clk);
    check("start_state0", int'(state), 0);
    check("start_pc0", int'(pc_w), 0);
    step();
    @(negedge clk);
    check("start_state1", int'(state), 1);
    check("start_pc1", int'(pc_w), 1);

    // Load-use through rs2.
    step();
    memread = 1; rd = 5; rs2 = 5; rs1 = 3;
    @(negedge clk);
    check("lu_bubble", int'(bubble), 1);
    check("lu_writes", int'(pc_w) + int'(ifid_w), 0);
    step();
    clear_ops();
    @(negedge clk);
    check("lu_bubble_off", int'(bubble), 0);
    check("lu_pc_back", int'(pc_w), 1);
    check("lu_hazard_cnt", int'(hazard_cnt), 1);

    // rd of x0 never hazards.
    step();
    memread = 1; rd = 0; rs1 = 0; rs2 = 0;
    @(negedge clk);
    check("x0_bubble", int'(bubble), 0);
    check("x0_pc", int'(pc_w), 1);
    step();
    clear_ops();
    @(negedge clk);
    check("x0_hazard_cnt", int'(hazard_cnt), 1);

    // Mem stall for 4 cycles over a branch and a load-use.
    step();
    mem_stall = 1; branch = 1; memread = 1; rd = 7; rs1 = 7;
    st2 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ms_stall", int'(stall), 1);
      check("ms_flush_bubble", int'(flush) + int'(bubble), 0);
      if (state == 2'd2) st2++;
      step();
    end
    mem_stall = 0;
    @(negedge clk);
    check("ms_state2_cycles", st2, 3);
    check("ms_stall_cnt", int'(stall_cnt), 4);
    check("mw_release_state", int'(state), 2);
    check("mw_release_bubble", int'(bubble), 1);
    check("mw_release_stall", int'(stall), 0);
    step();
    memread = 0; rd = 0; rs1 = 0;
    @(negedge clk);
    check("br_after_lu_state", int'(state), 1);
    check("br_after_lu_flush", int'(flush), 1);
    step();
    clear_ops();
    @(negedge clk);
    check("cnt_hazard2", int'(hazard_cnt), 2);
    check("cnt_flush1", int'(flush_cnt), 1);
    check("cnt_stall4", int'(stall_cnt), 4);

    // Reset in the middle of a memory wait.
    step();
    mem_stall = 1;
    step();
    @(negedge clk);
    check("mid_state2", int'(state), 2);
    rst = 1;
    #1;
    check("rst_mid_state", int'(state), 0);
    check("rst_mid_stall", int'(stall), 0);
    step();
    rst = 0; mem_stall = 0;
    @(negedge clk);
    check("post_rst_state", int'(state), 0);
    check("post_rst_cnt", int'(stall_cnt) + int'(hazard_cnt) + int'(flush_cnt), 0);
    check("post_rst_ctrl", int'(pc_w) + int'(ifid_w) + int'(flush) + int'(bubble) + int'(stall), 0);
    step();
    @(negedge clk);
    check("post_rst_run", int'(state), 1);
    check("post_rst_no_stall", int'(stall) + int'(flush), 0);

    // Saturation on the 2-bit instance.
    rst = 1;
    step();
    rst = 0;
    step();
    branch = 1;
    for (int i = 0; i < 5; i++) step();
    branch = 0;
    @(negedge clk);
    check("sat_flush3", int'(s_flush_cnt), 3);
    check("wide_flush5", int'(flush_cnt), 5);
    step();
    branch = 1;
    step();
    branch = 0;
    @(negedge clk);
    check("sat_flush_hold", int'(s_flush_cnt), 3);

    // Dropping start returns to idle and freezes counters.
    start = 0;
    step();
    branch = 1;
    @(negedge clk);
    check("idle_state", int'(state), 0);
    check("idle_pc", int'(pc_w), 0);
    check("idle_flush", int'(flush), 0);
    step();
    @(negedge clk);
    check("idle_flush_cnt", int'(flush_cnt), 6);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
